// File: rtl/moore_pkg.sv
// Shared types and widths for the Moore-machine project.
// The input conditioner's FSM state encoding lives here so debug logic can decode it.
package moore_pkg;

  localparam int BIT_COUNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL_HI = 2'd1,
    HELD    = 2'd2,
    QUAL_LO = 2'd3
  } cond_state_t;

endpackage

// File: rtl/sync2.sv
// One-bit two-flop synchroniser for asynchronous pins.
// Both flops reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/moore_input_conditioner.sv
// Synchronises the raw data/strobe pins and debounces the strobe.
// Emits one bit_valid pulse per qualified press and counts accepted bits.
module moore_input_conditioner
  import moore_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   din_raw,
  input  logic                   step_raw,
  output logic                   bit_out,
  output logic                   bit_valid,
  output logic                   busy,
  output logic [BIT_COUNT_W-1:0] bit_count,
  output cond_state_t            state_dbg
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic        din_s;
  logic        step_s;
  logic [CNT_W-1:0] cnt;
  cond_state_t state;

  sync2 u_sync_din (
    .clk (clk),
    .rst (rst),
    .d   (din_raw),
    .q   (din_s)
  );

  sync2 u_sync_step (
    .clk (clk),
    .rst (rst),
    .d   (step_raw),
    .q   (step_s)
  );

  assign state_dbg = state;

  // busy is kept as its own flop, updated alongside every state change,
  // so it is a pure register output rather than a decode of state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      bit_count <= '0;
    end else begin
      bit_valid <= 1'b0;
      if (!ena) begin
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (step_s) begin
              state <= QUAL_HI;
              cnt   <= CNT_ONE;
              busy  <= 1'b1;
            end
          end
          QUAL_HI: begin
            if (!step_s) begin
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end else if (cnt == CNT_LAST) begin
              state     <= HELD;
              cnt       <= '0;
              bit_out   <= din_s;
              bit_valid <= 1'b1;
              bit_count <= bit_count + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HELD: begin
            if (!step_s) begin
              state <= QUAL_LO;
              cnt   <= CNT_ONE;
            end
          end
          QUAL_LO: begin
            // A high sample during release qualification is a bounce: the
            // button is still considered pressed and no new pulse is issued.
            if (step_s) begin
              state <= HELD;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/moore_input_conditioner.md
# moore_input_conditioner

Front-end stage of the Moore-machine project, directly upstream of the Moore FSM core. It takes the raw serial-data pin and the raw "step" strobe pin from the Tiny Tapeout inputs, synchronises both, and debounces the strobe. For each qualified strobe press it delivers exactly one `bit_valid` pulse carrying a stable data bit, and it keeps a running count of accepted bits for debug readout on the bidirectional pins.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised samples required to qualify a strobe edge, press or release; legal range 2..255.
- `clk` input 1: single design clock; all flops on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ena` input 1: design-select; when 0, block is held idle synchronously.
- `din_raw` input 1: raw serial data bit (ui_in[0]), asynchronous to `clk`.
- `step_raw` input 1: raw strobe/button (ui_in[1]), asynchronous, bouncy.
- `bit_out` output 1: data bit latched at the moment of the last accepted press.
- `bit_valid` output 1: one-cycle pulse, one per accepted press; consumed by the Moore core as its advance strobe.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `bit_count` output 8: number of accepted presses, modulo 256.

## Operation
- Both raw inputs pass through a 2-flop synchroniser, giving `din_s` and `step_s`. No logic reads the raw inputs directly.
- FSM states: IDLE, QUAL_HI, HELD, QUAL_LO. A down-counter-free counter `cnt` has width clog2(DEBOUNCE_CYCLES+1).
- IDLE: if `step_s`=1, go to QUAL_HI with `cnt`=1.
- QUAL_HI:
  - `step_s`=0: go to IDLE, `cnt`=0. A bounce aborts the press with no pulse.
  - `step_s`=1 and `cnt`=DEBOUNCE_CYCLES-1: go to HELD, latch `bit_out`<=`din_s`, assert `bit_valid` for the next cycle, increment `bit_count`.
  - Otherwise: `cnt`++.
- HELD: if `step_s`=0, go to QUAL_LO with `cnt`=1. Otherwise stay; no further pulses regardless of hold duration.
- QUAL_LO:
  - `step_s`=1: go back to HELD. A release bounce does not re-trigger.
  - `step_s`=0 and `cnt`=DEBOUNCE_CYCLES-1: go to IDLE.
  - Otherwise: `cnt`++.
- `bit_count` wraps 255 -> 0 silently.
- `ena`=0 forces, synchronously:
  - FSM to IDLE and `cnt` to 0;
  - `bit_valid` to 0.
  - `bit_out` and `bit_count` hold their values.
  - Synchronisers keep running.
- Reset mid-press clears everything. A strobe still held high after reset release is qualified as a fresh press.

## Timing
- Reset values: `bit_out`=0, `bit_valid`=0, `busy`=0, `bit_count`=0; FSM=IDLE, `cnt`=0, synchroniser flops=0.
- All outputs are registered; there are no combinational paths from input to output.
- Press latency: with `step_raw` stable high, `bit_valid` is high in the cycle following edge number DEBOUNCE_CYCLES+2, counting from the first edge that samples `step_raw` high. With the default, that is the cycle after edge 6.
- `bit_out` is valid in the same cycle as `bit_valid` and stable until the next accepted press.
- Data setup: `din_raw` must be stable for at least 2 cycles before the qualifying edge. The sampled value is `din_s` at the edge where `cnt` reaches DEBOUNCE_CYCLES-1.
- Minimum press-to-press spacing is 2*DEBOUNCE_CYCLES+1 synchronised cycles: qualify high, qualify low, then one IDLE cycle.
- `busy` rises the cycle after `step_s` first goes high. It falls the cycle after QUAL_LO completes or after a QUAL_HI abort.

## Structure
- Shared package `moore_pkg`:
  - `cond_state_t` enum {IDLE, QUAL_HI, HELD, QUAL_LO};
  - `BIT_COUNT_W`=8.
- Sub-module `sync2`: a 1-bit, two-flop synchroniser with async active-high reset to 0, instantiated twice.
- The FSM, counter, and output registers live in `moore_input_conditioner`. The top-level `tt_um_*` wrapper maps active-low `rst_n` to `rst`.

## Test plan
- Reset then idle: assert `rst` for 3 cycles with inputs at 0 -> all outputs 0, `busy`=0; hold 50 cycles -> no `bit_valid`.
- Clean press: `din_raw`=1, `step_raw` high for 20 cycles, then low for 20 -> exactly one `bit_valid`, in the cycle after edge 6; `bit_out`=1; `bit_count`=1; `busy` returns to 0.
- Bouncy press: `step_raw` toggles 1,0,1,1,0 then holds high -> aborts produce no pulse; exactly one pulse after 4 consecutive synchronised highs.
- Release bounce: while HELD, drop `step_raw` low for 2 cycles, raise it for 3, then hold low -> no second pulse; `bit_count` increments by 1 total.
- Wrap and data: 257 clean presses with alternating `din_raw` -> `bit_out` alternates 1,0,1,...; `bit_count` ends at 1.
- `ena` drop and mid-press reset:
  - `ena`=0 during QUAL_HI -> no pulse, `busy`=0 next cycle.
  - Async `rst` pulse during HELD with `step_raw` still high -> outputs 0 immediately; a new pulse follows DEBOUNCE_CYCLES+2 edges after `rst` deasserts.
